// File: rtl/substitute.sv
// AES forward SubBytes stage: 4-bit header + 128-bit state, S-box applied to all 16 bytes.
// Latency: 2 edges. The load edge captures the word; the next edge updates data_out.
// No backpressure: one word accepted per load cycle; data_out holds until the next result.
// Optional build macro SUBSTITUTE_DONE_EN adds a one-cycle 'done' pulse per data_out update.
module substitute (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [131:0] data_in,
  output logic [131:0] data_out
`ifdef SUBSTITUTE_DONE_EN
  ,
  output logic         done
`endif
);

  // Standard FIPS-197 forward S-box as a combinational ROM.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; default: s = 8'h16;
    endcase
    return s;
  endfunction

  // Stage-1 capture register and the flag marking a word waiting for stage 2.
  logic [131:0] cap_q, cap_d;
  logic         pend_q, pend_d;
  // Stage-2 output register.
  logic [131:0] out_q, out_d;
  // Substituted state of the captured word; purely combinational between the stages.
  logic [127:0] sub_state;
  logic [3:0]   cap_hdr;

  assign cap_hdr = cap_q[131:128];

  // Run all 16 state bytes through the S-box in parallel.
  always_comb begin
    sub_state = '0;
    for (int k = 0; k < 16; k++) begin
      sub_state[8*k +: 8] = sbox(cap_q[8*k +: 8]);
    end
  end

  // Next-state: capture on load; a pending word updates the output one edge later.
  always_comb begin
    cap_d  = cap_q;
    pend_d = load;
    out_d  = out_q;
    if (load) begin
      cap_d = data_in;
    end
    if (pend_q) begin
      // A zero header marks the word invalid and forces an all-zero result.
      out_d = (cap_hdr != 4'h0) ? {cap_hdr, sub_state} : 132'h0;
    end
  end

  // Pipeline registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cap_q  <= 132'h0;
      pend_q <= 1'b0;
      out_q  <= 132'h0;
    end else begin
      cap_q  <= cap_d;
      pend_q <= pend_d;
      out_q  <= out_d;
    end
  end

  assign data_out = out_q;

`ifdef SUBSTITUTE_DONE_EN
  logic done_q, done_d;

  // done marks exactly the cycles in which data_out just took a new result.
  always_comb begin
    done_d = pend_q;
  end

  // done register, cleared by reset so an aborted word never pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_substitute.sv
module tb_substitute;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         load = 1'b0;
  logic [131:0] data_in = 132'h0;
  logic [131:0] data_out;
`ifdef SUBSTITUTE_DONE_EN
  logic         done;
`endif

  always #5 clk = ~clk;

  substitute dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef SUBSTITUTE_DONE_EN
    ,
    .done     (done)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [131:0] exp_q[$];
  logic [131:0] last_exp = 132'h0;
  logic [131:0] popped;
  // Bench timing model: a word loaded at edge N lands on data_out at edge N+1.
  logic pend_m = 1'b0;
  logic upd_m  = 1'b0;

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_m <= 1'b0;
      upd_m  <= 1'b0;
    end else begin
      pend_m <= load;
      upd_m  <= pend_m;
    end
  end

  // Monitor: pop and compare on each expected update, otherwise require hold.
  always @(negedge clk) begin
    if (!n_rst) last_exp = 132'h0;
    if (upd_m) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h expected no update", data_out);
      end else begin
        popped   = exp_q.pop_front();
        last_exp = popped;
        check("result", data_out, popped);
      end
    end else begin
      check("hold", data_out, last_exp);
    end
`ifdef SUBSTITUTE_DONE_EN
    check("done", {131'h0, done}, {131'h0, upd_m});
`endif
  end

  task automatic send(input logic [131:0] v, input logic [131:0] e);
    @(posedge clk);
    #2;
    load    = 1'b1;
    data_in = v;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #2;
    load = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    // Reset with a live word and load high: nothing may get through.
    n_rst   = 1'b0;
    load    = 1'b1;
    data_in = {4'h7, 128'h00112233445566778899AABBCCDDEEFF};
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", data_out, 132'h0);
    #1;
    load  = 1'b0;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);

    // Single valid word, then hold with data_in steady and then changed.
    send({4'h7, 128'h00112233445566778899AABBCCDDEEFF},
         {4'h7, 128'h638293C31BFC33F5C4EEACEA4BC12816});
    idle(3);
    #2;
    data_in = {4'hA, {16{8'h55}}};
    repeat (3) @(posedge clk);
    #1;
    check("hold_after_data_change", data_out, {4'h7, 128'h638293C31BFC33F5C4EEACEA4BC12816});

    // Invalid header gives all zeros.
    send({4'h0, 128'h00112233445566778899AABBCCDDEEFF}, 132'h0);
    idle(3);

    // Back-to-back pair.
    send({4'h1, 128'h0}, {4'h1, {16{8'h63}}});
    send({4'h2, {16{8'hFF}}}, {4'h2, {16{8'h16}}});
    idle(3);

    // Continuous load stream including an invalid word in the middle.
    send({4'h3, {16{8'h53}}}, {4'h3, {16{8'hED}}});
    send({4'hF, {16{8'h11}}}, {4'hF, {16{8'h82}}});
    send({4'h0, {16{8'hFF}}}, 132'h0);
    send({4'h5, 128'h000102030405060708090A0B0C0D0E0F},
         {4'h5, 128'h637C777BF26B6FC53001672BFED7AB76});
    send({4'h8, 128'hF0E0D0C0B0A090807060504030201000},
         {4'h8, 128'h8CE170BAE7E060CD51D0530904B7CA63});
    idle(3);

    // Reset between the load edge and the output edge aborts the word.
    @(posedge clk);
    #2;
    load    = 1'b1;
    data_in = {4'h9, {16{8'h00}}};
    @(posedge clk);
    #2;
    load  = 1'b0;
    #1;
    n_rst = 1'b0;
    #1;
    check("async_reset_out", data_out, 132'h0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_result_after_abort", data_out, 132'h0);

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: got %0d left expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
